// File: rtl/dioptase_reset_sequencer.sv
// dioptase_reset_sequencer: ordered reset release for the Dioptase SoC.
// Releases the DDR adapter, then the peripherals, then the CPU core, and
// handles software resets and DDR calibration loss after boot.
// Optional build macro DIOPTASE_RESET_CAL_TIMEOUT_EN adds a calibration
// wait timeout (parameter CAL_TIMEOUT) and the sticky cal_timeout output.
module dioptase_reset_sequencer #(
  parameter int unsigned SYNC_STAGES   = 3,
  parameter int unsigned PERIPH_DELAY  = 16,
  parameter int unsigned CORE_DELAY    = 64,
  parameter int unsigned SW_RST_CYCLES = 32,
  parameter int unsigned CNT_W         = 16
`ifdef DIOPTASE_RESET_CAL_TIMEOUT_EN
  ,
  parameter int unsigned CAL_TIMEOUT   = 2_000_000
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sw_rst_req,
  input  logic       ddr_calib_done,
  output logic       ddr_rst_n,
  output logic       periph_rst_n,
  output logic       core_rst_n,
  output logic [2:0] seq_state,
  output logic [1:0] rst_cause
`ifdef DIOPTASE_RESET_CAL_TIMEOUT_EN
  ,
  output logic       cal_timeout
`endif
);

  typedef enum logic [2:0] {
    S_SYNC   = 3'd0,
    S_DDR    = 3'd1,
    S_PERIPH = 3'd2,
    S_CAL    = 3'd3,
    S_CORE   = 3'd4,
    S_RUN    = 3'd5,
    S_SWRST  = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] L_PERIPH_LAST = CNT_W'(PERIPH_DELAY - 1);
  localparam logic [CNT_W-1:0] L_CORE_LAST   = CNT_W'(CORE_DELAY - 1);
  localparam logic [CNT_W-1:0] L_SW_LAST     = CNT_W'(SW_RST_CYCLES - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [1:0]           r_cause;
  logic [1:0]           w_cause_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic [SYNC_STAGES-1:0] r_rst_sync;
  logic                 w_rst_rel;
  logic                 r_cal_meta;
  logic                 r_cal_sync;
  logic                 r_cal_prev;
  logic                 w_cal_fall;
  logic                 r_sw_prev;
  logic                 w_sw_rise;
  logic                 r_ddr;
  logic                 r_periph;
  logic                 r_core;

`ifdef DIOPTASE_RESET_CAL_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(CAL_TIMEOUT + 1);
  localparam logic [TO_W-1:0] L_TO_LAST = TO_W'(CAL_TIMEOUT - 1);
  logic [TO_W-1:0] r_to_cnt;
  logic            r_cal_timeout;
  logic            w_to_set;
`endif

  assign w_rst_rel  = r_rst_sync[SYNC_STAGES-1];
  assign w_cal_fall = r_cal_prev & ~r_cal_sync;
  assign w_sw_rise  = sw_rst_req & ~r_sw_prev;

  // Reset-release synchronizer: asserts with rst_n, releases after SYNC_STAGES edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= '0;
    else        r_rst_sync <= {r_rst_sync[SYNC_STAGES-2:0], 1'b1};
  end

  // Calibration flag synchronizer plus one history flop for fall detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cal_meta <= 1'b0;
      r_cal_sync <= 1'b0;
      r_cal_prev <= 1'b0;
    end else begin
      r_cal_meta <= ddr_calib_done;
      r_cal_sync <= r_cal_meta;
      r_cal_prev <= r_cal_sync;
    end
  end

  // Software request history so a held level triggers only once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sw_prev <= 1'b0;
    else        r_sw_prev <= sw_rst_req;
  end

  // Next-state and reset-cause selection; calibration loss outranks software reset.
  always_comb begin
    w_state_nxt = r_state;
    w_cause_nxt = r_cause;
`ifdef DIOPTASE_RESET_CAL_TIMEOUT_EN
    w_to_set    = 1'b0;
`endif
    case (r_state)
      S_SYNC:   if (w_rst_rel) w_state_nxt = S_DDR;
      S_DDR:    if (r_cnt == L_PERIPH_LAST) w_state_nxt = S_PERIPH;
      S_PERIPH: w_state_nxt = S_CAL;
      S_CAL: begin
        if (r_cal_sync) w_state_nxt = S_CORE;
`ifdef DIOPTASE_RESET_CAL_TIMEOUT_EN
        else if (r_to_cnt == L_TO_LAST) begin
          w_state_nxt = S_CORE;
          w_to_set    = 1'b1;
        end
`endif
      end
      S_CORE: begin
        if (w_cal_fall) begin
          w_state_nxt = S_CAL;
          w_cause_nxt = 2'd2;
        end else if (r_cnt == L_CORE_LAST) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (w_cal_fall) begin
          w_state_nxt = S_CAL;
          w_cause_nxt = 2'd2;
        end else if (w_sw_rise) begin
          w_state_nxt = S_SWRST;
          w_cause_nxt = 2'd1;
        end
      end
      S_SWRST:  if (r_cnt == L_SW_LAST) w_state_nxt = S_DDR;
      default:  w_state_nxt = S_SYNC;
    endcase
  end

  // State, cause and output registers; outputs follow the next state so they
  // change on the same edge as the state itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_SYNC;
      r_cause  <= 2'd0;
      r_ddr    <= 1'b0;
      r_periph <= 1'b0;
      r_core   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cause  <= w_cause_nxt;
      r_ddr    <= (w_state_nxt != S_SYNC);
      r_periph <= (w_state_nxt inside {S_PERIPH, S_CAL, S_CORE, S_RUN});
      r_core   <= (w_state_nxt == S_RUN);
    end
  end

  // Shared delay counter: cleared on every state entry, runs only in timed states.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_state_nxt != r_state) begin
      r_cnt <= '0;
    end else if (r_state inside {S_DDR, S_CORE, S_SWRST}) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

`ifdef DIOPTASE_RESET_CAL_TIMEOUT_EN
  // Calibration wait timer and sticky timeout flag (cleared only by rst_n).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt      <= '0;
      r_cal_timeout <= 1'b0;
    end else begin
      if (r_state == S_CAL && w_state_nxt == S_CAL) r_to_cnt <= r_to_cnt + 1'b1;
      else                                          r_to_cnt <= '0;
      if (w_to_set) r_cal_timeout <= 1'b1;
    end
  end

  assign cal_timeout = r_cal_timeout;
`endif

  assign ddr_rst_n    = r_ddr;
  assign periph_rst_n = r_periph;
  assign core_rst_n   = r_core;
  assign seq_state    = r_state;
  assign rst_cause    = r_cause;

endmodule

// File: tb/tb_dioptase_reset_sequencer.sv
// Directed testbench for dioptase_reset_sequencer with default delays
// (SYNC_STAGES=3, PERIPH_DELAY=16, CORE_DELAY=64, SW_RST_CYCLES=32).
module tb_dioptase_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sw_rst_req;
  logic       ddr_calib_done;
  logic       ddr_rst_n;
  logic       periph_rst_n;
  logic       core_rst_n;
  logic [2:0] seq_state;
  logic [1:0] rst_cause;
`ifdef DIOPTASE_RESET_CAL_TIMEOUT_EN
  logic       cal_timeout;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int order_viol = 0;

  dioptase_reset_sequencer #(
    .SYNC_STAGES  (3),
    .PERIPH_DELAY (16),
    .CORE_DELAY   (64),
    .SW_RST_CYCLES(32),
    .CNT_W        (16)
`ifdef DIOPTASE_RESET_CAL_TIMEOUT_EN
    ,
    .CAL_TIMEOUT  (100)
`endif
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sw_rst_req    (sw_rst_req),
    .ddr_calib_done(ddr_calib_done),
    .ddr_rst_n     (ddr_rst_n),
    .periph_rst_n  (periph_rst_n),
    .core_rst_n    (core_rst_n),
    .seq_state     (seq_state),
    .rst_cause     (rst_cause)
`ifdef DIOPTASE_RESET_CAL_TIMEOUT_EN
    ,
    .cal_timeout   (cal_timeout)
`endif
  );

  always #5 clk = ~clk;

  // Release order: core implies peripherals implies DDR.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && ((core_rst_n && !periph_rst_n) || (periph_rst_n && !ddr_rst_n)))
      order_viol++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Edges until the selected reset output reads 1; -1 if the bound expires.
  task automatic wait_for(input int which, input int bound, output int n);
    logic v;
    n = -1;
    for (int i = 1; i <= bound; i++) begin
      tick();
      v = (which == 0) ? ddr_rst_n : (which == 1) ? periph_rst_n : core_rst_n;
      if (v) begin n = i; break; end
    end
  endtask

  task automatic wait_state(input logic [2:0] st, input int bound, output int n);
    n = -1;
    for (int i = 1; i <= bound; i++) begin
      tick();
      if (seq_state == st) begin n = i; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sw_rst_req = 1'b0; ddr_calib_done = 1'b1;
    repeat (10) tick();
    n_cmp++; if (ddr_rst_n !== 1'b0) begin n_bad++; $display("FAIL rst_ddr: got %b expected 0", ddr_rst_n); end
    n_cmp++; if (periph_rst_n !== 1'b0) begin n_bad++; $display("FAIL rst_periph: got %b expected 0", periph_rst_n); end
    n_cmp++; if (core_rst_n !== 1'b0) begin n_bad++; $display("FAIL rst_core: got %b expected 0", core_rst_n); end
    n_cmp++; if (seq_state !== 3'd0) begin n_bad++; $display("FAIL rst_state: got %0d expected 0", seq_state); end
    n_cmp++; if (rst_cause !== 2'd0) begin n_bad++; $display("FAIL rst_cause: got %0d expected 0", rst_cause); end
  endtask

  task automatic test_power_on();
    int n;
    rst_n = 1'b1;
    wait_for(0, 10, n);
    n_cmp++; if (!(n == 3 || n == 4)) begin n_bad++; $display("FAIL pon_ddr_latency: got %0d expected 3..4", n); end
    wait_for(1, 40, n);
    n_cmp++; if (n !== 16) begin n_bad++; $display("FAIL pon_periph_after_ddr: got %0d expected 16", n); end
    wait_for(2, 200, n);
    n_cmp++; if (n !== 66) begin n_bad++; $display("FAIL pon_core_after_periph: got %0d expected 66", n); end
    n_cmp++; if (seq_state !== 3'd5) begin n_bad++; $display("FAIL pon_run_state: got %0d expected 5", seq_state); end
  endtask

  task automatic test_cal_stall();
    int n;
    int stall_bad;
    rst_n = 1'b0; ddr_calib_done = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    wait_state(3'd3, 60, n);
    n_cmp++; if (!(n >= 20 && n <= 22)) begin n_bad++; $display("FAIL stall_cal_entry: got %0d expected 20..22", n); end
    stall_bad = 0;
    repeat (500) begin
      tick();
      if (seq_state !== 3'd3 || core_rst_n !== 1'b0 || periph_rst_n !== 1'b1) stall_bad++;
    end
    n_cmp++; if (stall_bad != 0) begin n_bad++; $display("FAIL stall_hold: got %0d bad cycles expected 0", stall_bad); end
    ddr_calib_done = 1'b1;
    wait_state(3'd4, 10, n);
    n_cmp++; if (n !== 3) begin n_bad++; $display("FAIL stall_core_entry: got %0d expected 3", n); end
    wait_for(2, 100, n);
    n_cmp++; if (n !== 64) begin n_bad++; $display("FAIL stall_core_delay: got %0d expected 64", n); end
  endtask

  task automatic test_sw_reset();
    int t_ddr_state, t_periph, t_core, ddr_drop;
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    n_cmp++; if (seq_state !== 3'd6) begin n_bad++; $display("FAIL sw_state: got %0d expected 6", seq_state); end
    n_cmp++; if ({ddr_rst_n, periph_rst_n, core_rst_n} !== 3'b100) begin n_bad++; $display("FAIL sw_outputs: got %b expected 100", {ddr_rst_n, periph_rst_n, core_rst_n}); end
    n_cmp++; if (rst_cause !== 2'd1) begin n_bad++; $display("FAIL sw_cause: got %0d expected 1", rst_cause); end
    t_ddr_state = -1; t_periph = -1; t_core = -1; ddr_drop = 0;
    for (int i = 1; i <= 150; i++) begin
      tick();
      if (!ddr_rst_n) ddr_drop++;
      if (t_ddr_state < 0 && seq_state == 3'd1) t_ddr_state = i;
      if (t_periph < 0 && periph_rst_n) t_periph = i;
      if (t_core < 0 && core_rst_n) t_core = i;
    end
    n_cmp++; if (t_ddr_state !== 32) begin n_bad++; $display("FAIL sw_low_time: got %0d expected 32", t_ddr_state); end
    n_cmp++; if (ddr_drop != 0) begin n_bad++; $display("FAIL sw_ddr_held: got %0d low cycles expected 0", ddr_drop); end
    n_cmp++; if (t_periph !== 48) begin n_bad++; $display("FAIL sw_periph_rerelease: got %0d expected 48", t_periph); end
    n_cmp++; if (t_core !== 114) begin n_bad++; $display("FAIL sw_core_rerelease: got %0d expected 114", t_core); end
  endtask

  task automatic test_held_req();
    int entries;
    logic [2:0] prev;
    entries = 0; prev = seq_state;
    sw_rst_req = 1'b1;
    repeat (1000) begin
      tick();
      if (seq_state == 3'd6 && prev != 3'd6) entries++;
      prev = seq_state;
    end
    sw_rst_req = 1'b0;
    repeat (3) tick();
    n_cmp++; if (entries !== 1) begin n_bad++; $display("FAIL held_entries: got %0d expected 1", entries); end
    n_cmp++; if (seq_state !== 3'd5) begin n_bad++; $display("FAIL held_final_state: got %0d expected 5", seq_state); end
  endtask

  task automatic test_collision();
    int n;
    ddr_calib_done = 1'b0;
    tick(); tick();
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    n_cmp++; if (seq_state !== 3'd3) begin n_bad++; $display("FAIL coll_state: got %0d expected 3", seq_state); end
    n_cmp++; if (rst_cause !== 2'd2) begin n_bad++; $display("FAIL coll_cause: got %0d expected 2", rst_cause); end
    n_cmp++; if ({ddr_rst_n, periph_rst_n, core_rst_n} !== 3'b110) begin n_bad++; $display("FAIL coll_outputs: got %b expected 110", {ddr_rst_n, periph_rst_n, core_rst_n}); end
    ddr_calib_done = 1'b1;
    wait_for(2, 100, n);
    n_cmp++; if (n !== 67) begin n_bad++; $display("FAIL coll_recover: got %0d expected 67", n); end
  endtask

  task automatic test_mid_reset();
    int n;
    // Abort from S_CORE reached through a calibration drop (cause 2).
    ddr_calib_done = 1'b0;
    wait_state(3'd3, 10, n);
    ddr_calib_done = 1'b1;
    wait_state(3'd4, 10, n);
    repeat (3) tick();
    n_cmp++; if (rst_cause !== 2'd2 || seq_state !== 3'd4) begin n_bad++; $display("FAIL mid_core_pre: got state %0d cause %0d expected 4/2", seq_state, rst_cause); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({ddr_rst_n, periph_rst_n, core_rst_n} !== 3'b000) begin n_bad++; $display("FAIL mid_core_outputs: got %b expected 000", {ddr_rst_n, periph_rst_n, core_rst_n}); end
    n_cmp++; if (seq_state !== 3'd0 || rst_cause !== 2'd0) begin n_bad++; $display("FAIL mid_core_state: got state %0d cause %0d expected 0/0", seq_state, rst_cause); end
    tick(); tick();
    rst_n = 1'b1;
    wait_for(2, 200, n);
    n_cmp++; if (!(n >= 85 && n <= 88)) begin n_bad++; $display("FAIL mid_full_latency: got %0d expected 85..88", n); end
    // Abort from S_SWRST (cause 1, DDR released).
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    repeat (5) tick();
    n_cmp++; if (seq_state !== 3'd6 || rst_cause !== 2'd1) begin n_bad++; $display("FAIL mid_sw_pre: got state %0d cause %0d expected 6/1", seq_state, rst_cause); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (ddr_rst_n !== 1'b0) begin n_bad++; $display("FAIL mid_sw_ddr: got %b expected 0", ddr_rst_n); end
    n_cmp++; if (seq_state !== 3'd0 || rst_cause !== 2'd0) begin n_bad++; $display("FAIL mid_sw_state: got state %0d cause %0d expected 0/0", seq_state, rst_cause); end
    tick(); tick();
    rst_n = 1'b1;
    wait_for(2, 200, n);
  endtask

`ifdef DIOPTASE_RESET_CAL_TIMEOUT_EN
  task automatic test_cal_timeout();
    int n;
    rst_n = 1'b0; ddr_calib_done = 1'b0;
    tick();
    rst_n = 1'b1;
    wait_state(3'd3, 60, n);
    n_cmp++; if (cal_timeout !== 1'b0) begin n_bad++; $display("FAIL to_initial: got %b expected 0", cal_timeout); end
    wait_state(3'd4, 200, n);
    n_cmp++; if (n !== 100) begin n_bad++; $display("FAIL to_wait: got %0d expected 100", n); end
    n_cmp++; if (cal_timeout !== 1'b1) begin n_bad++; $display("FAIL to_flag: got %b expected 1", cal_timeout); end
    wait_for(2, 200, n);
    n_cmp++; if (n !== 64) begin n_bad++; $display("FAIL to_core_delay: got %0d expected 64", n); end
  endtask
`endif

  task automatic test_order();
    n_cmp++; if (order_viol != 0) begin n_bad++; $display("FAIL release_order: got %0d violations expected 0", order_viol); end
  endtask

  initial begin
    test_reset();
    test_power_on();
`ifndef DIOPTASE_RESET_CAL_TIMEOUT_EN
    test_cal_stall();
`endif
    test_sw_reset();
    test_held_req();
    test_collision();
    test_mid_reset();
`ifdef DIOPTASE_RESET_CAL_TIMEOUT_EN
    test_cal_timeout();
`endif
    test_order();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dioptase_reset_sequencer.md
Name: dioptase_reset_sequencer

Overview:
- Generates ordered, glitch-free reset releases for the Dioptase SoC from the board reset button, a software reset request and the DDR calibration status.
- Sits between the board wrapper and the `dioptase` core, and drives the currently unused board reset line into the core, its peripherals and the DDR adapter.
- Release order: DDR adapter, then peripherals (PS/2, UART, SD, VGA), then the CPU core.

Parameters:
- SYNC_STAGES, 3: flops in the reset-release synchronizer; legal range 2..4.
- PERIPH_DELAY, 16: clk cycles from ddr_rst_n release to periph_rst_n release; must be ≥1.
- CORE_DELAY, 64: clk cycles from calibration-ok to core_rst_n release; must be ≥1.
- SW_RST_CYCLES, 32: core/periph low time for a software reset; must be ≥1.
- CNT_W, 16: width of the shared delay counter; must hold the largest delay.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  asynchronous active-low reset (board CPU_RESETN).
- sw_rst_req  in  1  software reset request from the MMIO block; single-cycle pulse or level.
- ddr_calib_done  in  1  DDR adapter calibration-complete flag; asynchronous to the sequencer, synchronized internally.
- ddr_rst_n  out  1  reset to the DDR/SRAM adapter.
- periph_rst_n  out  1  reset to all peripherals.
- core_rst_n  out  1  reset to the CPU pipeline.
- seq_state  out  3  current FSM state encoding, for debug and MMIO.
- rst_cause  out  2  cause of the last reset: 0 = power/button, 1 = software, 2 = calibration lost.

Behaviour:
- Reset assertion:
  - rst_n low asynchronously forces ddr_rst_n, periph_rst_n and core_rst_n to 0.
  - seq_state goes to S_SYNC, the counter to 0 and rst_cause to 0.
- Reset release: rst_n deassertion passes through the SYNC_STAGES synchronizer, which is async-cleared by rst_n. The FSM leaves S_SYNC on the first cycle the synchronizer output is 1.
- All outputs are registered. Each output changes only on a clk edge, except during asynchronous assertion.
- ddr_calib_done passes through a 2-flop synchronizer before use.
- States (encoding is fixed for verification):
  - S_SYNC (0): all outputs 0 → S_DDR.
  - S_DDR (1): ddr_rst_n=1. Count PERIPH_DELAY cycles, then → S_PERIPH.
  - S_PERIPH (2): periph_rst_n=1 on entry. → S_CAL.
  - S_CAL (3): wait for synchronized calib = 1, then clear the counter → S_CORE.
  - S_CORE (4): count CORE_DELAY cycles, then core_rst_n=1 → S_RUN.
  - S_RUN (5): all outputs 1.
  - S_SWRST (6): core_rst_n=0, periph_rst_n=0, ddr_rst_n unchanged (stays 1). Count SW_RST_CYCLES, then → S_DDR with the counter cleared. Re-entering S_DDR repeats the peripheral delay.
- Counter: the counter clears on every state entry. A delay of N gives exactly N cycles in the state; exit occurs on the edge where count == N-1.
- Software reset:
  - Honoured only in S_RUN: rising edge of sw_rst_req → S_SWRST, rst_cause=1.
  - Requests in any other state are ignored; they are not queued.
  - A level held high retriggers only after it has been seen low.
- Calibration loss:
  - In S_CORE or S_RUN, synchronized calib falling to 0 → core_rst_n=0 next cycle, rst_cause=2, → S_CAL. Peripherals stay out of reset.
  - Calibration loss takes priority over sw_rst_req in the same cycle.
- rst_cause keeps its value until a new cause or until rst_n is asserted.
- Any rst_n assertion mid-sequence aborts immediately to S_SYNC.
- Latency from rst_n release to core_rst_n=1, with calib already 1: SYNC_STAGES + PERIPH_DELAY + 2 (S_PERIPH, S_CAL) + 2 (calib sync) + CORE_DELAY cycles, within ±1 depending on where the calib sync overlaps.

Optional Feature:
- Macro: DIOPTASE_RESET_CAL_TIMEOUT_EN.
- When defined:
  - Parameter CAL_TIMEOUT (default 2_000_000 cycles) applies to S_CAL.
  - If calibration is not seen within the timeout, the FSM proceeds to S_CORE anyway.
  - A sticky output cal_timeout (1 bit, reset 0) is set; only rst_n clears it.
- When undefined: S_CAL waits indefinitely, and the cal_timeout port and its counter logic do not exist.

Test Plan:
- Power-on: rst_n low 10 cycles, calib tied 1, defaults → ddr_rst_n rises at cycle 3 after release, periph_rst_n at 3+16+1, core_rst_n at about 3+16+4+64; the order is never violated.
- Calib stalls: calib held 0 for 500 cycles after S_CAL entry, then 1 → core_rst_n rises exactly 64 cycles after the S_CORE entry that follows calib sync; seq_state is 3 throughout the stall.
- Software reset: one-cycle sw_rst_req in S_RUN → core_rst_n and periph_rst_n low for 32 cycles, ddr_rst_n stays 1, rst_cause=1, then the full periph/core re-release.
- Held request and collision: sw_rst_req held high 1000 cycles → exactly one S_SWRST entry. Calib dropping in the same cycle as sw_rst_req → S_CAL, rst_cause=2.
- Mid-sequence reset: rst_n pulsed low in S_CORE and in S_SWRST → all outputs 0 in the same cycle (asynchronously), state 0, rst_cause=0.
- With DIOPTASE_RESET_CAL_TIMEOUT_EN and CAL_TIMEOUT=100: calib never rises → after 100 cycles in S_CAL, cal_timeout=1 and core_rst_n releases CORE_DELAY later.
